pipeline_buffer_decode: RTL

//  Parametrised elastic fetch->decode buffer; replaces the single-entry stall/flush decode register.

---
 rtl/pipeline_buffer_decode_if.sv | 46 ++++
 rtl/pipeline_buffer_decode.sv | 96 +++++++++
 2 files changed

// File: rtl/pipeline_buffer_decode_if.sv
// Fetch->decode buffer bus: fetch-side bundle and handshake, decode-side head bundle,
// flush and occupancy. The buffer uses the slave modport; its driver uses master.
interface pipeline_buffer_decode_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic                   log_trace_i;
    logic                   branch_pred_taken_i;
    logic [1:0]             btb_way_i;
    logic [ADDR_WIDTH-1:0]  pc_target_addr_pred_i;
    logic [INSTR_WIDTH-1:0] instr_i;
    logic [DATA_WIDTH-1:0]  pc_i;
    logic [DATA_WIDTH-1:0]  pc_plus4_i;

    logic                   out_valid_o;
    logic                   out_ready_i;
    logic                   log_trace_o;
    logic                   branch_pred_taken_o;
    logic [1:0]             btb_way_o;
    logic [ADDR_WIDTH-1:0]  pc_target_addr_pred_o;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0]  pc_o;
    logic [DATA_WIDTH-1:0]  pc_plus4_o;
    logic [CNT_W-1:0]       count_o;

    modport slave (
        input  flush_i, in_valid_i, log_trace_i, branch_pred_taken_i, btb_way_i,
               pc_target_addr_pred_i, instr_i, pc_i, pc_plus4_i, out_ready_i,
        output in_ready_o, out_valid_o, log_trace_o, branch_pred_taken_o, btb_way_o,
               pc_target_addr_pred_o, instr_o, pc_o, pc_plus4_o, count_o
    );

    modport master (
        output flush_i, in_valid_i, log_trace_i, branch_pred_taken_i, btb_way_i,
               pc_target_addr_pred_i, instr_i, pc_i, pc_plus4_i, out_ready_i,
        input  in_ready_o, out_valid_o, log_trace_o, branch_pred_taken_o, btb_way_o,
               pc_target_addr_pred_o, instr_o, pc_o, pc_plus4_o, count_o
    );
endinterface

// File: rtl/pipeline_buffer_decode.sv
// Elastic DEPTH-entry fetch->decode FIFO with single-cycle flush.
// Optional PIPELINE_BUFFER_DECODE_BYPASS_EN: empty buffer forwards the input bundle combinationally.
module pipeline_buffer_decode #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    pipeline_buffer_decode_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BW    = 4 + ADDR_WIDTH + INSTR_WIDTH + 2 * DATA_WIDTH;

    typedef logic [BW-1:0] bundle_t;

    bundle_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    bundle_t in_bundle;
    bundle_t head_bundle;
    logic    empty, full, push, pop, out_valid;

    assign in_bundle = {bus.log_trace_i, bus.branch_pred_taken_i, bus.btb_way_i,
                        bus.pc_target_addr_pred_i, bus.instr_i, bus.pc_i, bus.pc_plus4_i};

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign pop   = ~empty & bus.out_ready_i & ~bus.flush_i;

`ifdef PIPELINE_BUFFER_DECODE_BYPASS_EN
    logic byp;
    // A bypassed bundle that decode accepts immediately never occupies an entry.
    assign byp         = empty & bus.in_valid_i & ~bus.flush_i;
    assign push        = bus.in_valid_i & ~full & ~bus.flush_i & ~(byp & bus.out_ready_i);
    assign out_valid   = ~empty | byp;
    assign head_bundle = !empty ? mem_q[rd_ptr_q] : (byp ? in_bundle : '0);
`else
    assign push        = bus.in_valid_i & ~full & ~bus.flush_i;
    assign out_valid   = ~empty;
    assign head_bundle = !empty ? mem_q[rd_ptr_q] : '0;
`endif

    assign bus.in_ready_o  = ~full;
    assign bus.out_valid_o = out_valid;
    assign bus.count_o     = cnt_q;
    assign {bus.log_trace_o, bus.branch_pred_taken_o, bus.btb_way_o,
            bus.pc_target_addr_pred_o, bus.instr_o, bus.pc_o, bus.pc_plus4_o} = head_bundle;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage carries no reset; the empty mux hides stale contents.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= in_bundle;
    end

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            assert (!(push && !pop && full)) else $error("buffer overflow");
            assert (!(pop && empty))         else $error("buffer underflow");
        end
    end
endmodule
